// File: rtl/wb_demux2x32.sv
// wb_demux2x32: registered 1-to-2 write-back demultiplexer.
// Each word goes to one of two per-output FIFOs, so a stalled consumer
// never blocks the other output. out0 feeds the GPR write port and out1
// feeds the coprocessor/HI-LO write port.
// Optional feature macro: WB_DEMUX_ZERO_DROP_EN. When it is defined, writes
// to $zero (addr 0) are accepted, discarded, and counted on drop_count.
module wb_demux2x32 #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sel,
  input  logic [AW-1:0]           in_addr,
  input  logic [DW-1:0]           in_data,
  output logic                    out0_valid,
  input  logic                    out0_ready,
  output logic [AW-1:0]           out0_addr,
  output logic [DW-1:0]           out0_data,
  output logic [$clog2(DEPTH):0]  out0_count,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic [AW-1:0]           out1_addr,
  output logic [DW-1:0]           out1_data,
  output logic [$clog2(DEPTH):0]  out1_count
`ifdef WB_DEMUX_ZERO_DROP_EN
  ,
  output logic [7:0]              drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 is out0 and index 1 is out1 in every array below.
  logic [EW-1:0] mem_q  [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] rptr_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    oready;
  logic          drop;

  assign oready = {out1_ready, out0_ready};

  // Handshake decode: readiness of the selected FIFO, push/pop strobes, next counts.
  always_comb begin
    drop = 1'b0;
`ifdef WB_DEMUX_ZERO_DROP_EN
    drop = (in_addr == '0);
`endif
    in_ready = drop || (cnt_q[in_sel] != FULL);
    for (int k = 0; k < 2; k++) begin
      push[k]  = in_valid && in_ready && !drop && (in_sel == 1'(k));
      pop[k]   = (cnt_q[k] != '0) && oready[k];
      cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  // FIFO storage, pointers and counts. Reset clears the array so that heads read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cnt_q[k]  <= '0;
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[k][i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (push[k]) begin
          mem_q[k][wptr_q[k]] <= {in_addr, in_data};
          wptr_q[k]           <= wptr_q[k] + 1'b1;
        end
        if (pop[k]) begin
          rptr_q[k] <= rptr_q[k] + 1'b1;
        end
      end
    end
  end

  assign out0_valid             = (cnt_q[0] != '0);
  assign out1_valid             = (cnt_q[1] != '0);
  assign {out0_addr, out0_data} = mem_q[0][rptr_q[0]];
  assign {out1_addr, out1_data} = mem_q[1][rptr_q[1]];
  assign out0_count             = cnt_q[0];
  assign out1_count             = cnt_q[1];

`ifdef WB_DEMUX_ZERO_DROP_EN
  logic [7:0] drop_cnt_q;
  logic [7:0] drop_cnt_d;

  // Saturating count of discarded $zero writes.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wb_demux2x32.sv
// Bench for wb_demux2x32: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_wb_demux2x32;
  localparam int DEPTH = 2;

`ifdef WB_DEMUX_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sel;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [4:0]  out0_addr, out1_addr;
  logic [31:0] out0_data, out1_data;
  logic [1:0]  out0_count, out1_count;
`ifdef WB_DEMUX_ZERO_DROP_EN
  logic [7:0]  drop_count;
`endif

  wb_demux2x32 #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_addr  (out0_addr),
    .out0_data  (out0_data),
    .out0_count (out0_count),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_addr  (out1_addr),
    .out1_data  (out1_data),
    .out1_count (out1_count)
`ifdef WB_DEMUX_ZERO_DROP_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue of {addr,data} per output plus a drop counter.
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int          dc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit m_drop();
    return ZD && (in_addr == 5'd0);
  endfunction

  function automatic bit m_ready();
    int sz;
    sz = in_sel ? q1.size() : q0.size();
    return m_drop() || (sz != DEPTH);
  endfunction

  // Compare every observable output against the model.
  task automatic compare_all();
    `CHK("in_ready", in_ready, m_ready());
    `CHK("out0_valid", out0_valid, q0.size() != 0);
    `CHK("out0_count", out0_count, q0.size());
    if (q0.size() != 0) begin
      `CHK("out0_addr", out0_addr, q0[0][36:32]);
      `CHK("out0_data", out0_data, q0[0][31:0]);
    end
    `CHK("out1_valid", out1_valid, q1.size() != 0);
    `CHK("out1_count", out1_count, q1.size());
    if (q1.size() != 0) begin
      `CHK("out1_addr", out1_addr, q1[0][36:32]);
      `CHK("out1_data", out1_data, q1[0][31:0]);
    end
`ifdef WB_DEMUX_ZERO_DROP_EN
    `CHK("drop_count", drop_count, dc);
`endif
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_update();
    bit rdy, p0, p1, pu;
    rdy = m_ready();
    p0  = (q0.size() != 0) && out0_ready;
    p1  = (q1.size() != 0) && out1_ready;
    pu  = in_valid && rdy && !m_drop();
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (pu) begin
      if (in_sel) q1.push_back({in_addr, in_data});
      else        q0.push_back({in_addr, in_data});
    end
    if (in_valid && m_drop() && dc < 255) dc++;
  endtask

  // One cycle: check at the falling edge, update the model at the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic drive(input bit v, input bit s, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 5'd0, 32'd0);
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #12;
    `CHK("rst_in_ready", in_ready, 1);
    `CHK("rst_out0_valid", out0_valid, 0);
    `CHK("rst_out1_valid", out1_valid, 0);
    `CHK("rst_out0_count", out0_count, 0);
    `CHK("rst_out1_count", out1_count, 0);
    `CHK("rst_out0_payload", {out0_addr, out0_data}, 0);
    `CHK("rst_out1_payload", {out1_addr, out1_data}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single push reaches out0 one cycle later.
    drive(1, 0, 5'd5, 32'hDEADBEEF);
    step();
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t1_out0_valid", out0_valid, 1);
    total++;
    if (out0_addr !== 5'd5) begin
      bad++;
      $display("FAIL t1_out0_addr: got %0h", out0_addr);
    end
    total++;
    if (out0_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL t1_out0_data: got %0h", out0_data);
    end
    `CHK("t1_out0_count", out0_count, 1);
    `CHK("t1_out1_valid", out1_valid, 0);
    step();
    `CHK("t1_hold_data", out0_data, 32'hDEADBEEF);
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;

    // Fill out1; out0 traffic still flows; out1 drains in order.
    drive(1, 1, 5'd1, 32'h11); step();
    drive(1, 1, 5'd2, 32'h22); step();
    #1;
    `CHK("t2_ready_sel1_full", in_ready, 0);
    `CHK("t2_out1_count", out1_count, 2);
    in_sel = 1'b0;
    #1;
    `CHK("t2_ready_sel0", in_ready, 1);
    drive(1, 0, 5'd3, 32'h33); step();
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t2_out0_count", out0_count, 1);
    `CHK("t2_out0_data", out0_data, 32'h33);
    `CHK("t2_out1_head", out1_data, 32'h11);
    out1_ready = 1'b1;
    step();
    `CHK("t2_out1_second", out1_data, 32'h22);
    `CHK("t2_out1_count1", out1_count, 1);
    step();
    `CHK("t2_out1_empty", out1_valid, 0);
    out1_ready = 1'b0;
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;

    // Full FIFO: pop with in_valid held, push lands the following cycle.
    drive(1, 1, 5'd4, 32'h44); step();
    drive(1, 1, 5'd5, 32'h55); step();
    drive(1, 1, 5'd6, 32'h66);
    out1_ready = 1'b1;
    #1;
    `CHK("t3_ready_full", in_ready, 0);
    step();
    `CHK("t3_count_after_pop", out1_count, 1);
    `CHK("t3_head_55", out1_data, 32'h55);
    `CHK("t3_ready_again", in_ready, 1);
    step();
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t3_head_66", out1_data, 32'h66);
    `CHK("t3_count_66", out1_count, 1);
    step();
    `CHK("t3_drained", out1_count, 0);
    out1_ready = 1'b0;

    // Alternating stream with both consumers ready.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, i[0], 5'(i + 8), 32'h100 + 32'(i));
      step();
      total++;
      if (out0_count > 2'd1) begin
        bad++;
        $display("FAIL t4_cnt0_le1: got %0d", out0_count);
      end
      total++;
      if (out1_count > 2'd1) begin
        bad++;
        $display("FAIL t4_cnt1_le1: got %0d", out1_count);
      end
    end
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t4_last_out1", out1_data, 32'h107);
    step();
    step();
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Reset with both FIFOs full.
    drive(1, 0, 5'd9, 32'hA0); step();
    drive(1, 0, 5'd10, 32'hA1); step();
    drive(1, 1, 5'd11, 32'hB0); step();
    drive(1, 1, 5'd12, 32'hB1); step();
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t5_pre_cnt0", out0_count, 2);
    `CHK("t5_pre_cnt1", out1_count, 2);
    #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    dc = 0;
    #1;
    `CHK("t5_out0_valid", out0_valid, 0);
    `CHK("t5_out1_valid", out1_valid, 0);
    `CHK("t5_cnt0", out0_count, 0);
    `CHK("t5_cnt1", out1_count, 0);
    `CHK("t5_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step();

    // $zero handling.
    drive(1, 0, 5'd7, 32'hC0); step();
    drive(1, 0, 5'd8, 32'hC1); step();
`ifdef WB_DEMUX_ZERO_DROP_EN
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 5'd0, 32'hE0 + 32'(i));
      #1;
      `CHK("t6_zero_ready", in_ready, 1);
      step();
    end
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t6_drop_count", drop_count, 3);
    `CHK("t6_out0_count", out0_count, 2);
    `CHK("t6_out0_head", out0_data, 32'hC0);
`else
    drive(1, 1, 5'd0, 32'hE0);
    step();
    drive(0, 0, 5'd0, 32'd0);
    `CHK("t6_zero_queued_cnt", out1_count, 1);
    `CHK("t6_zero_queued_data", out1_data, 32'hE0);
    `CHK("t6_out0_count", out0_count, 2);
    `CHK("t6_out0_head", out0_data, 32'hC0);
`endif
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    step();
    step();
    `CHK("end_out0_empty", out0_valid, 0);
    `CHK("end_out1_empty", out1_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_demux2x32.md
# wb_demux2x32

Registered 1-to-2 demultiplexer for the write-back path: it steers one 32-bit data word and its 5-bit destination register address to one of two consumers. Output 0 is the GPR file write port and output 1 is the coprocessor/HI-LO write port. Each output has its own small FIFO, so a stalled consumer does not block traffic already queued for the other. It is the steering counterpart to the 2-input select muxes in the datapath.

## Interface
Parameters:
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid is also high.
- in_sel  in  1  destination: 0 selects out0, 1 selects out1.
- in_addr  in  AW  destination register address.
- in_data  in  DW  write-back data.
- out0_valid / out1_valid  out  1  head entry valid.
- out0_ready / out1_ready  in  1  consumer takes the head entry.
- out0_addr / out1_addr  out  AW  head entry address.
- out0_data / out1_data  out  DW  head entry data.
- out0_count / out1_count  out  clog2(DEPTH)+1  FIFO occupancy.
- drop_count  out  8  count of discarded $zero writes. Present only with the macro; see Configuration.

## Operation
- in_ready = (count[in_sel] != DEPTH). in_ready depends combinationally on in_sel and is never conditioned on in_valid.
- A push happens when in_valid and in_ready are both high. The {addr, data} pair is written to FIFO[in_sel] at its write pointer, and that pointer advances.
- A pop on output k happens when outk_valid and outk_ready are both high. The read pointer for k advances.
- outk_valid = (count_k != 0). outk_addr and outk_data come from a register-array read at the read pointer.
- Each output preserves the order of its own entries. There is no ordering between the two outputs.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count is tracked separately.
- Push and pop on the same FIFO in the same cycle: count is unchanged and both pointers advance.
  - Full FIFO: in_ready is low, so no push occurs even if a pop happens that cycle. There is no pass-through when full.
  - Empty FIFO: no pop occurs and the pushed entry appears next cycle. There is no bypass.
- The idle output's FIFO is never affected by traffic to the other output.

## Timing
- Reset (asynchronous assert; deassert sampled on the next clk edge):
  - all counts and pointers are 0;
  - out0_valid = out1_valid = 0;
  - in_ready = 1;
  - outk_addr and outk_data read as 0, because the storage array is cleared;
  - drop_count = 0.
- Latency: a push at edge N is visible on outk_valid/addr/data after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
- Throughput: 1 word per cycle sustained per output when its consumer holds ready high.
- Reset mid-operation: all queued entries are lost immediately. Outputs go invalid asynchronously and no partial entry survives.
- Payload stability: while outk_valid is high and outk_ready is low, outk_addr and outk_data hold stable.

## Configuration
- Macro: WB_DEMUX_ZERO_DROP_EN.
- Defined:
  - an input with in_addr == 0 (MIPS $zero) is accepted with in_ready forced to 1, regardless of FIFO state, and is never enqueued;
  - drop_count increments by 1 per dropped word and saturates at 255;
  - the drop_count port exists.
- Undefined:
  - $zero writes are queued like any other address;
  - the drop_count port and its logic are absent.

## Test plan
- Reset, then push {sel=0, addr=5, data=0xDEADBEEF} with out0_ready=0 -> cycle 1: out0_valid=1, out0_addr=5, out0_data=0xDEADBEEF, out0_count=1, out1_valid=0.
- Fill out1 with 2 words (0x11, 0x22), out1_ready=0 -> in_ready=0 for sel=1 but 1 for sel=0; a sel=0 word (0x33) still enters out0; raising out1_ready pops 0x11 then 0x22 in order.
- Full FIFO with simultaneous pop and in_valid (sel=1) -> no push that cycle; count drops 2->1; the push succeeds the next cycle; no data loss or duplication.
- Stream 8 back-to-back words alternating sel with both readies high -> each output delivers its 4 words in order; pointers wrap twice; counts never exceed 1.
- Assert rst_n=0 with both FIFOs holding 2 entries -> valids drop immediately, counts read 0, in_ready=1.
- With WB_DEMUX_ZERO_DROP_EN defined, push addr=0 three times while out0 is full -> in_ready=1 each time, drop_count=3, out0 contents unchanged.
